// File: rtl/rf_pkg.sv
// rtl/rf_pkg.sv - shared constants and slot type for the register-file writeback path
package rf_pkg;

  localparam int DEF_DATA_W = 64;
  localparam int DEF_ADDR_W = 5;
  localparam int ZERO_REG   = 0;

  typedef struct packed {
    logic                  valid;
    logic [DEF_ADDR_W-1:0] rd;
    logic [DEF_DATA_W-1:0] data;
  } wb_slot_t;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin picker: first request at or after ptr
module rr_arbiter #(
  parameter  int N  = 2,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx,
  output logic          grant_valid
);

  // Scan N candidates starting at ptr, wrapping, and take the first requester.
  always_comb begin
    int cand;
    grant       = '0;
    grant_idx   = '0;
    grant_valid = 1'b0;
    cand        = 0;
    for (int k = 0; k < N; k++) begin
      cand = int'(ptr) + k;
      if (cand >= N) cand = cand - N;
      if (!grant_valid && req[cand[IW-1:0]]) begin
        grant[cand[IW-1:0]] = 1'b1;
        grant_idx           = cand[IW-1:0];
        grant_valid         = 1'b1;
      end
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - shares the register-file write port among NUM_REQ sources; WB_PENDING_EN adds pending_mask
module regfile_wb_arbiter
  import rf_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int ADDR_W  = DEF_ADDR_W
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_REQ-1:0]          req_valid,
  output logic [NUM_REQ-1:0]          req_ready,
  input  logic [NUM_REQ*ADDR_W-1:0]   req_rd,
  input  logic [NUM_REQ*DATA_W-1:0]   req_data,
  output logic                        rf_we,
  output logic [ADDR_W-1:0]           rf_rd,
  output logic [DATA_W-1:0]           rf_wdata,
  output logic [$clog2(NUM_REQ)-1:0]  grant_id,
  output logic                        busy
`ifdef WB_PENDING_EN
  ,
  output logic [(2**ADDR_W)-1:0]      pending_mask
`endif
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef struct packed {
    logic              valid;
    logic [ADDR_W-1:0] rd;
    logic [DATA_W-1:0] data;
  } slot_t;

  slot_t              slots [NUM_REQ];
  logic [NUM_REQ-1:0] occ;
  logic [IW-1:0]      rr_ptr;
  logic [NUM_REQ-1:0] grant_vec;
  logic [IW-1:0]      win_idx;
  logic               win_valid;
  logic               wr_en;

  // Gather occupancy bits into a vector for the arbiter and busy flag.
  always_comb begin
    occ = '0;
    for (int i = 0; i < NUM_REQ; i++) occ[i] = slots[i].valid;
  end

  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .req         (occ),
    .ptr         (rr_ptr),
    .grant       (grant_vec),
    .grant_idx   (win_idx),
    .grant_valid (win_valid)
  );

  // A write is issued only from registered slot state and never while reset is held.
  always_comb begin
    wr_en     = win_valid && !reset;
    req_ready = reset ? '0 : (~occ | grant_vec);
    busy      = |occ;
  end

  // Drive the register-file port from the winning slot; all zeros when idle.
  always_comb begin
    rf_we    = wr_en;
    rf_rd    = '0;
    rf_wdata = '0;
    grant_id = '0;
    if (wr_en) begin
      grant_id = win_idx;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (grant_vec[i]) begin
          rf_rd    = slots[i].rd;
          rf_wdata = slots[i].data;
        end
      end
    end
  end

  // Slot update: a handshake overwrites the slot (x0 leaves it empty), otherwise a grant empties it.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_REQ; i++) slots[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (req_valid[i] && req_ready[i]) begin
          slots[i].valid <= (req_rd[i*ADDR_W +: ADDR_W] != ADDR_W'(ZERO_REG));
          slots[i].rd    <= req_rd[i*ADDR_W +: ADDR_W];
          slots[i].data  <= req_data[i*DATA_W +: DATA_W];
        end else if (grant_vec[i]) begin
          slots[i].valid <= 1'b0;
        end
      end
    end
  end

  // Round-robin pointer moves just past the winner on every grant and holds otherwise.
  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr <= '0;
    end else if (win_valid) begin
      rr_ptr <= (win_idx == IW'(NUM_REQ - 1)) ? '0 : win_idx + IW'(1);
    end
  end

`ifdef WB_PENDING_EN
  // Mark every register that still has an undrained write; x0 never counts.
  always_comb begin
    pending_mask = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (slots[i].valid) pending_mask[slots[i].rd] = 1'b1;
    end
    pending_mask[ZERO_REG] = 1'b0;
  end
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb/tb_regfile_wb_arbiter.sv - randomized scoreboard bench for regfile_wb_arbiter
module tb_regfile_wb_arbiter;

  localparam int NUM_REQ = 2;
  localparam int DATA_W  = 64;
  localparam int ADDR_W  = 5;

  logic                       clk = 1'b0;
  logic                       reset;
  logic [NUM_REQ-1:0]         req_valid;
  logic [NUM_REQ-1:0]         req_ready;
  logic [NUM_REQ*ADDR_W-1:0]  req_rd;
  logic [NUM_REQ*DATA_W-1:0]  req_data;
  logic                       rf_we;
  logic [ADDR_W-1:0]          rf_rd;
  logic [DATA_W-1:0]          rf_wdata;
  logic [$clog2(NUM_REQ)-1:0] grant_id;
  logic                       busy;
`ifdef WB_PENDING_EN
  logic [(2**ADDR_W)-1:0]     pending_mask;
`endif

  regfile_wb_arbiter #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_rd    (req_rd),
    .req_data  (req_data),
    .rf_we     (rf_we),
    .rf_rd     (rf_rd),
    .rf_wdata  (rf_wdata),
    .grant_id  (grant_id),
    .busy      (busy)
`ifdef WB_PENDING_EN
    ,
    .pending_mask (pending_mask)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [ADDR_W-1:0] rd;
    logic [DATA_W-1:0] data;
  } wr_t;

  // Reference model: per-source FIFO of accepted writes plus a rotating priority pointer.
  wr_t         exp_q [NUM_REQ][$];
  int          model_ptr;
  bit          exp_ready [NUM_REQ];
  int          checks;
  int          passed;
  int          pushed;
  logic [DATA_W-1:0] rf_model [2**ADDR_W];
  int          wr_log [$];
  int          wr_count;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Register file behind the port: commits whatever the DUT writes.
  always @(posedge clk) begin
    if (rf_we) begin
      rf_model[rf_rd] <= rf_wdata;
      wr_log.push_back(int'(rf_rd));
      wr_count <= wr_count + 1;
    end
  end

  // Monitor: compare DUT outputs against the model and retire the expected winner.
  always @(negedge clk) begin : mon
    int win;
    int c;
    logic [(2**ADDR_W)-1:0] pm;
    if (reset) begin
      check("ready_in_reset", 64'(req_ready), 64'd0);
      check("we_in_reset", 64'(rf_we), 64'd0);
      for (int i = 0; i < NUM_REQ; i++) begin
        exp_q[i].delete();
        exp_ready[i] = 1'b0;
      end
      model_ptr = 0;
    end else begin
      win = -1;
      for (int k = 0; k < NUM_REQ; k++) begin
        c = (model_ptr + k) % NUM_REQ;
        if (win < 0 && exp_q[c].size() > 0) win = c;
      end
      check("busy", 64'(busy), 64'(win >= 0));
      check("rf_we", 64'(rf_we), 64'(win >= 0));
      for (int i = 0; i < NUM_REQ; i++) begin
        exp_ready[i] = (exp_q[i].size() == 0) || (i == win);
        check($sformatf("req_ready[%0d]", i), 64'(req_ready[i]), 64'(exp_ready[i]));
      end
      pm = '0;
      for (int i = 0; i < NUM_REQ; i++)
        if (exp_q[i].size() > 0) pm[exp_q[i][0].rd] = 1'b1;
      pm[0] = 1'b0;
`ifdef WB_PENDING_EN
      check("pending_mask", 64'(pending_mask), 64'(pm));
`endif
      if (win >= 0) begin
        check("grant_id", 64'(grant_id), 64'(win));
        check("rf_rd", 64'(rf_rd), 64'(exp_q[win][0].rd));
        check("rf_wdata", 64'(rf_wdata), 64'(exp_q[win][0].data));
        void'(exp_q[win].pop_front());
        model_ptr = (win + 1) % NUM_REQ;
      end else begin
        check("idle_rd", 64'(rf_rd), 64'd0);
        check("idle_wdata", 64'(rf_wdata), 64'd0);
        check("idle_grant", 64'(grant_id), 64'd0);
      end
    end
  end

  // Apply one cycle of stimulus; accepted non-x0 writes become expected responses.
  task automatic step(input logic [NUM_REQ-1:0] v, input logic [NUM_REQ*ADDR_W-1:0] rd,
                      input logic [NUM_REQ*DATA_W-1:0] d, input logic rst);
    wr_t w;
    reset     = rst;
    req_valid = v;
    req_rd    = rd;
    req_data  = d;
    @(negedge clk);
    #1;
    if (!rst) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (v[i] && exp_ready[i] && rd[i*ADDR_W +: ADDR_W] != '0) begin
          w.rd   = rd[i*ADDR_W +: ADDR_W];
          w.data = d[i*DATA_W +: DATA_W];
          exp_q[i].push_back(w);
          pushed++;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DATA_W-1:0] rnd64();
    return {$urandom(), $urandom()};
  endfunction

  initial begin
    int base;
    checks = 0; passed = 0; pushed = 0; wr_count = 0; model_ptr = 0;
    for (int i = 0; i < 2**ADDR_W; i++) rf_model[i] = '0;
    for (int i = 0; i < NUM_REQ; i++) exp_ready[i] = 1'b0;
    reset = 1'b1; req_valid = '0; req_rd = '0; req_data = '0;
    @(posedge clk); #1;
    step('0, '0, '0, 1'b1);
    step('0, '0, '0, 1'b1);

    // single write to r5
    step(2'b01, {5'd0, 5'd5}, {64'd0, 64'hDEAD_BEEF}, 1'b0);
    step('0, '0, '0, 1'b0);
    step('0, '0, '0, 1'b0);
    check("r5_value", rf_model[5], 64'hDEAD_BEEF);

    // x0 write is accepted and dropped
    base = wr_count;
    step(2'b10, {5'd0, 5'd0}, {64'hFFFF, 64'd0}, 1'b0);
    step('0, '0, '0, 1'b0);
    check("x0_no_write", 64'(wr_count - base), 64'd0);
    check("r0_value", rf_model[0], 64'd0);

    // contention: both sources every cycle
    base = wr_count;
    pushed = 0;
    for (int k = 0; k < 100; k++) step(2'b11, {5'd2, 5'd1}, {rnd64(), rnd64()}, 1'b0);
    step('0, '0, '0, 1'b0);
    step('0, '0, '0, 1'b0);
    check("contention_writes", 64'(wr_count - base), 64'(pushed));

    // streaming from source 0
    wr_log.delete();
    for (int k = 1; k <= 10; k++) step(2'b01, {5'd0, 5'(k)}, {64'd0, rnd64()}, 1'b0);
    step('0, '0, '0, 1'b0);
    step('0, '0, '0, 1'b0);
    check("stream_len", 64'(wr_log.size()), 64'd10);
    for (int k = 0; k < 10 && k < wr_log.size(); k++)
      check($sformatf("stream_rd%0d", k), 64'(wr_log[k]), 64'(k + 1));

    // reset with both slots loaded (slot0 rd7, slot1 rd12)
    step(2'b11, {5'd12, 5'd7}, {rnd64(), rnd64()}, 1'b0);
    base = wr_count;
    step('0, '0, '0, 1'b1);
    step('0, '0, '0, 1'b0);
    step('0, '0, '0, 1'b0);
    check("reset_discard", 64'(wr_count - base), 64'd0);

    // randomized traffic with occasional reset
    for (int k = 0; k < 400; k++)
      step(NUM_REQ'($urandom()), {5'($urandom_range(0, 31)), 5'($urandom_range(0, 31))},
           {rnd64(), rnd64()}, $urandom_range(0, 39) == 0);
    step('0, '0, '0, 1'b0);
    step('0, '0, '0, 1'b0);
    step('0, '0, '0, 1'b0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
